// File: rtl/adc_sample_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
// Holds the FSM state enumeration and the reported-value width.
package adc_sample_sched_pkg;

    // Width of the reported sensor value and the period timer
    localparam int ValueWidth = 16;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_POWERUP  = 3'd2,
        ST_CONVERT  = 3'd3,
        ST_NOTIFY   = 3'd4
    } state_e;

    // Absolute difference computed one bit wider so it never wraps
    function automatic logic [ValueWidth:0] abs_diff(
        input logic [ValueWidth-1:0] i_a,
        input logic [ValueWidth-1:0] i_b
    );
        logic [ValueWidth:0] w_a;
        logic [ValueWidth:0] w_b;
        w_a = {1'b0, i_a};
        w_b = {1'b0, i_b};
        return (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    endfunction

endpackage

// File: rtl/adc_sample_sched_timer.sv
// Loadable down-counter that paces the idle interval between samples.
// Load wins over decrement; the count saturates at zero.
module adc_period_timer
    import adc_sample_sched_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [ValueWidth-1:0] i_load_value,
    input  logic                  i_dec,
    output logic                  o_zero
);

    logic [ValueWidth-1:0] r_count;

    // Count register: reload on request, otherwise count down to zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ValueWidth'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/adc_sample_sched.sv
// Periodic sensor power-up / ADC conversion scheduler.
// Reports a new value with an interrupt when it moves past a threshold.
module adc_sample_sched
    import adc_sample_sched_pkg::*;
#(
    parameter int AdcWidth     = 10,
    parameter int TimeoutWidth = 8
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic                    Enable_i,
    input  logic [15:0]             PeriodCounterPreset_i,
    input  logic [15:0]             Threshold_i,
    input  logic [TimeoutWidth-1:0] ReadyTimeout_i,
    output logic                    SensorPower_o,
    output logic                    SensorStart_o,
    input  logic                    SensorReady_i,
    output logic                    AdcStart_o,
    input  logic                    AdcDone_i,
    input  logic [AdcWidth-1:0]     AdcValue_i,
    output logic [15:0]             SensorValue_o,
    output logic                    CpuIntr_o,
    output logic                    Error_o
);

    // Timeout compare is done one bit wider so count+1 never wraps
    localparam int TcW = TimeoutWidth + 1;

    state_e                  r_state;
    state_e                  w_next_state;

    logic [TimeoutWidth-1:0] r_tocnt;
    logic [AdcWidth-1:0]     r_capture;
    logic [ValueWidth-1:0]   r_value;
    logic                    r_intr;
    logic                    r_error;

    logic                    w_power;
    logic                    w_start;
    logic                    w_adc;
    logic                    w_timer_load;
    logic                    w_timer_dec;
    logic                    w_timer_zero;
    logic                    w_tocnt_clr;
    logic                    w_tocnt_inc;
    logic                    w_set_error;
    logic                    w_error_clr;
    logic                    w_capture;
    logic                    w_report;

    logic [TcW-1:0]          w_tocnt_next;
    logic                    w_timeout_hit;
    logic [ValueWidth-1:0]   w_capture_ext;
    logic [ValueWidth:0]     w_diff;
    logic                    w_over;

    assign w_tocnt_next  = {1'b0, r_tocnt} + TcW'(1);
    assign w_timeout_hit = (ReadyTimeout_i != '0) &&
                           (w_tocnt_next == {1'b0, ReadyTimeout_i});

    assign w_capture_ext = ValueWidth'(r_capture);
    assign w_diff        = abs_diff(w_capture_ext, r_value);
    assign w_over        = (w_diff > {1'b0, Threshold_i});

    adc_period_timer u_timer (
        .i_clk        (Clk_i),
        .i_rst        (Reset_i),
        .i_load       (w_timer_load),
        .i_load_value (PeriodCounterPreset_i),
        .i_dec        (w_timer_dec),
        .o_zero       (w_timer_zero)
    );

    // State register
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, datapath strobes and Moore output decode
    always_comb begin
        w_next_state = r_state;
        w_power      = 1'b0;
        w_start      = 1'b0;
        w_adc        = 1'b0;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        w_tocnt_clr  = 1'b0;
        w_tocnt_inc  = 1'b0;
        w_set_error  = 1'b0;
        w_error_clr  = 1'b0;
        w_capture    = 1'b0;
        w_report     = 1'b0;

        unique case (r_state)
            ST_POWERUP: begin
                w_power = 1'b1;
                w_start = 1'b1;
            end
            ST_CONVERT: begin
                w_power = 1'b1;
                w_start = 1'b1;
                w_adc   = 1'b1;
            end
            default: begin
                w_power = 1'b0;
            end
        endcase

        if (!Enable_i) begin
            w_next_state = ST_DISABLED;
        end else begin
            unique case (r_state)
                ST_DISABLED: begin
                    w_timer_load = 1'b1;
                    w_error_clr  = 1'b1;
                    w_next_state = ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_timer_zero) begin
                        w_timer_load = 1'b1;
                        w_tocnt_clr  = 1'b1;
                        w_next_state = ST_POWERUP;
                    end else begin
                        w_timer_dec = 1'b1;
                    end
                end
                ST_POWERUP: begin
                    if (SensorReady_i) begin
                        w_next_state = ST_CONVERT;
                    end else if (w_timeout_hit) begin
                        w_set_error  = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_tocnt_inc = 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (AdcDone_i) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_NOTIFY;
                    end
                end
                ST_NOTIFY: begin
                    w_report     = w_over;
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_DISABLED;
                end
            endcase
        end
    end

    // Timeout counter, capture, reported value, interrupt and error flag
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            r_tocnt   <= '0;
            r_capture <= '0;
            r_value   <= '0;
            r_intr    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_intr <= w_report;
            if (w_tocnt_clr) begin
                r_tocnt <= '0;
            end else if (w_tocnt_inc) begin
                r_tocnt <= r_tocnt + TimeoutWidth'(1);
            end
            if (w_capture) begin
                r_capture <= AdcValue_i;
            end
            if (w_report) begin
                r_value <= w_capture_ext;
            end
            if (w_error_clr) begin
                r_error <= 1'b0;
            end else if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    assign SensorPower_o = w_power;
    assign SensorStart_o = w_start;
    assign AdcStart_o    = w_adc;
    assign SensorValue_o = r_value;
    assign CpuIntr_o     = r_intr;
    assign Error_o       = r_error;

endmodule

// File: doc/adc_sample_sched.md
ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

Interface
REQ-001 SHALL have parameter AdcWidth, default 10, the external ADC result width.
REQ-002 SHALL have parameter TimeoutWidth, default 8, the sensor-ready timeout counter width.
REQ-003 SHALL have port Clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_i, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port Enable_i, input, 1, the sampling enable (level).
REQ-006 SHALL have port PeriodCounterPreset_i, input, 16, the idle cycles between samples.
REQ-007 SHALL have port Threshold_i, input, 16, the minimum absolute change that is reported.
REQ-008 SHALL have port ReadyTimeout_i, input, TimeoutWidth, the maximum POWERUP cycles; 0 disables the timeout.
REQ-009 SHALL have port SensorPower_o, output, 1, the sensor supply enable.
REQ-010 SHALL have port SensorStart_o, output, 1, the sensor measurement start.
REQ-011 SHALL have port SensorReady_i, input, 1, the sensor output-valid indication.
REQ-012 SHALL have port AdcStart_o, output, 1, the ADC convert request (level).
REQ-013 SHALL have port AdcDone_i, input, 1, the ADC conversion complete.
REQ-014 SHALL have port AdcValue_i, input, AdcWidth, the ADC result, valid while AdcDone_i=1.
REQ-015 SHALL have port SensorValue_o, output, 16, the last reported value, zero-extended.
REQ-016 SHALL have port CpuIntr_o, output, 1, a one-cycle pulse on each report.
REQ-017 SHALL have port Error_o, output, 1, the sticky sensor-timeout flag.

Function
REQ-018 SHALL implement FSM states DISABLED, IDLE, POWERUP, CONVERT and NOTIFY.
REQ-019 SHALL, in DISABLED, drive SensorPower_o, SensorStart_o, AdcStart_o and CpuIntr_o to 0; on Enable_i=1 it SHALL load the timer with PeriodCounterPreset_i, clear Error_o and go to IDLE.
REQ-020 SHALL, in IDLE, decrement the timer each cycle; on the cycle it reads 0 it SHALL go to POWERUP and reload PeriodCounterPreset_i. A preset of 0 gives a 1-cycle IDLE.
REQ-021 SHALL, in POWERUP, drive SensorPower_o=1 and SensorStart_o=1 and count cycles; on SensorReady_i=1 it SHALL go to CONVERT.
REQ-022 SHALL, in POWERUP with ReadyTimeout_i!=0, when the count reaches ReadyTimeout_i without SensorReady_i, set Error_o=1 and go to IDLE with no report.
REQ-023 SHALL, in CONVERT, drive SensorPower_o=1, SensorStart_o=1 and AdcStart_o=1; on AdcDone_i=1 it SHALL capture AdcValue_i and go to NOTIFY.
REQ-024 SHALL ignore AdcDone_i outside CONVERT.
REQ-025 SHALL, in NOTIFY, drive all sensor and ADC outputs to 0 and compute the absolute difference |captured - SensorValue_o| at 17-bit width with no wrap.
REQ-026 SHALL, when the difference is strictly greater than Threshold_i, update SensorValue_o and pulse CpuIntr_o for exactly 1 cycle in the cycle after NOTIFY; when it is equal or less, make no update. It SHALL then go to IDLE.
REQ-027 SHALL, on Enable_i=0 in any state, go to DISABLED on the next edge with outputs 0 that cycle. SensorValue_o SHALL be retained; Error_o SHALL hold until the next enable.
REQ-028 SHALL sample PeriodCounterPreset_i, Threshold_i and ReadyTimeout_i only at their point of use; changes mid-interval do not affect the running timer.
REQ-029 SHALL have a minimum latency of 1 cycle from SensorReady_i to AdcStart_o and 2 cycles from AdcDone_i to CpuIntr_o.

Reset
REQ-030 SHALL, with Reset_i=1 at an edge, enter DISABLED and clear the timer, timeout count, capture register, SensorValue_o, CpuIntr_o and Error_o, regardless of Enable_i.
REQ-031 SHALL, on reset mid-conversion, drop AdcStart_o and SensorPower_o on that edge.

Structure
REQ-032 SHALL place the state enumeration and the 16-bit value width constant in shared package adc_sample_sched_pkg.
REQ-033 SHALL implement the period timer as sub-module adc_period_timer (16-bit loadable down-counter with zero flag).

Verification
REQ-034 SHALL verify: preset=3, Enable_i rises -> SensorPower_o rises after exactly 4 IDLE cycles, and the period repeats.
REQ-035 SHALL verify: Threshold_i=10, samples 100, 105, 120 -> CpuIntr_o pulses on 100 and 120 only; SensorValue_o=100 then 120.
REQ-036 SHALL verify: Threshold_i=5, samples 50, 55 -> no report on 55 (difference equal to threshold); SensorValue_o stays 50.
REQ-037 SHALL verify: ReadyTimeout_i=4, SensorReady_i held 0 -> Error_o=1 after 4 POWERUP cycles, then IDLE, then Error_o cleared by Enable_i 0->1.
REQ-038 SHALL verify: Enable_i dropped in CONVERT -> AdcStart_o=0 next cycle, no CpuIntr_o, SensorValue_o unchanged.
REQ-039 SHALL verify: Reset_i pulsed during CONVERT with Enable_i=1 -> all outputs 0, SensorValue_o=0, restart from DISABLED.
